// File: rtl/seq_detect_multi.sv
`default_nettype none
// seq_detect_multi: NUM_CH independent runtime-programmable serial pattern detectors
// with per-channel match pulses, any-match flag and saturating match counters. Rev 1.0
module seq_detect_multi #(
  parameter int  NUM_CH  = 4,
  parameter int  MAX_LEN = 8,
  parameter int  CNT_W   = 8,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_we_i,
  input  logic [CH_W-1:0]         cfg_ch_i,
  input  logic [MAX_LEN-1:0]      cfg_pattern_i,
  input  logic [LEN_W-1:0]        cfg_len_i,
  input  logic                    cfg_overlap_i,
  input  logic [NUM_CH-1:0]       ch_en_i,
  input  logic [NUM_CH-1:0]       din_i,
  input  logic                    cnt_clr_i,
  output logic [NUM_CH-1:0]       match_o,
  output logic                    any_match_o,
  output logic [NUM_CH*CNT_W-1:0] match_cnt_o
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [LEN_W-1:0] cfg_len_clamped;
  assign cfg_len_clamped = (cfg_len_i > LEN_MAX) ? LEN_MAX : cfg_len_i;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // The oldest history bit is never compared, so only MAX_LEN-1 bits are stored.
    logic [MAX_LEN-2:0] hist_q, hist_d;
    logic [MAX_LEN-1:0] pattern_q, hist_n, len_mask;
    logic [LEN_W-1:0]   len_q, fill_q, fill_d, fill_n;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               overlap_q, match_q, match_d, cfg_sel, hit;

    always_comb begin
      cfg_sel  = cfg_we_i && (cfg_ch_i == CH_W'(i));
      hist_n   = {hist_q, din_i[i]};
      fill_n   = (fill_q == LEN_MAX) ? fill_q : fill_q + 1'b1;
      len_mask = '0;
      for (int b = 0; b < MAX_LEN; b++) begin
        len_mask[b] = (LEN_W'(b) < len_q);
      end
      hit = ch_en_i[i] && !cfg_sel && (len_q != '0) && (fill_n >= len_q) &&
            (((hist_n ^ pattern_q) & len_mask) == '0);

      hist_d  = hist_n[MAX_LEN-2:0];
      fill_d  = fill_n;
      match_d = hit;
      // Non-overlap mode restarts history so the next match needs len fresh bits.
      if (cfg_sel || !ch_en_i[i] || (hit && !overlap_q)) begin
        hist_d = '0;
        fill_d = '0;
      end

      cnt_d = cnt_q;
      if (cnt_clr_i) begin
        cnt_d = '0;
      end else if (hit && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        pattern_q <= '0;
        len_q     <= '0;
        overlap_q <= 1'b0;
        hist_q    <= '0;
        fill_q    <= '0;
        match_q   <= 1'b0;
        cnt_q     <= '0;
      end else begin
        if (cfg_sel) begin
          pattern_q <= cfg_pattern_i;
          len_q     <= cfg_len_clamped;
          overlap_q <= cfg_overlap_i;
        end
        hist_q  <= hist_d;
        fill_q  <= fill_d;
        match_q <= match_d;
        cnt_q   <= cnt_d;
      end
    end

    assign match_o[i]                    = match_q;
    assign match_cnt_o[i*CNT_W +: CNT_W] = cnt_q;
  end

  assign any_match_o = |match_o;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_multi.sv
`default_nettype none
// tb_seq_detect_multi: directed and randomized checks of seq_detect_multi against a
// queue-based reference model of the received bit stream. Rev 1.0
module tb_seq_detect_multi;
  localparam int NUM_CH  = 3;
  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;
  localparam int CH_W    = 2;
  localparam int LEN_W   = 4;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic                    cfg_we = 1'b0;
  logic [CH_W-1:0]         cfg_ch = '0;
  logic [MAX_LEN-1:0]      cfg_pattern = '0;
  logic [LEN_W-1:0]        cfg_len = '0;
  logic                    cfg_overlap = 1'b0;
  logic [NUM_CH-1:0]       ch_en = '1;
  logic [NUM_CH-1:0]       din = '0;
  logic                    cnt_clr = 1'b0;
  logic [NUM_CH-1:0]       match_s;
  logic                    any_s;
  logic [NUM_CH*CNT_W-1:0] cnt_s;

  int checks = 0;
  int errors = 0;

  seq_detect_multi #(.NUM_CH(NUM_CH), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) u_dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_we_i      (cfg_we),
    .cfg_ch_i      (cfg_ch),
    .cfg_pattern_i (cfg_pattern),
    .cfg_len_i     (cfg_len),
    .cfg_overlap_i (cfg_overlap),
    .ch_en_i       (ch_en),
    .din_i         (din),
    .cnt_clr_i     (cnt_clr),
    .match_o       (match_s),
    .any_match_o   (any_s),
    .match_cnt_o   (cnt_s)
  );

  always #5 clk = ~clk;

  // Reference model: bits received since the last history clear, oldest first.
  bit                 hq      [NUM_CH][$];
  logic [MAX_LEN-1:0] m_pat   [NUM_CH];
  int                 m_len   [NUM_CH];
  bit                 m_ov    [NUM_CH];
  int                 m_cnt   [NUM_CH];
  bit                 m_match [NUM_CH];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      hq[ch].delete();
      m_pat[ch]   = '0;
      m_len[ch]   = 0;
      m_ov[ch]    = 1'b0;
      m_cnt[ch]   = 0;
      m_match[ch] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      bit hit;
      hit = 1'b0;
      if (cfg_we && (int'(cfg_ch) == ch)) begin
        m_pat[ch] = cfg_pattern;
        m_len[ch] = (int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len);
        m_ov[ch]  = cfg_overlap;
        hq[ch].delete();
      end else if (!ch_en[ch]) begin
        hq[ch].delete();
      end else begin
        hq[ch].push_back(din[ch]);
        if (hq[ch].size() > MAX_LEN) void'(hq[ch].pop_front());
        if (m_len[ch] > 0 && hq[ch].size() >= m_len[ch]) begin
          hit = 1'b1;
          for (int k = 0; k < m_len[ch]; k++)
            if (hq[ch][hq[ch].size() - m_len[ch] + k] != m_pat[ch][m_len[ch] - 1 - k]) hit = 1'b0;
        end
        if (hit && !m_ov[ch]) hq[ch].delete();
      end
      if (cnt_clr) m_cnt[ch] = 0;
      else if (hit && m_cnt[ch] < CNT_SAT) m_cnt[ch]++;
      m_match[ch] = hit;
    end
  endtask

  task automatic compare_all(input string tag);
    logic any_exp;
    any_exp = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      check_eq($sformatf("%s match[%0d]", tag, ch), 32'(match_s[ch]), 32'(m_match[ch]));
      check_eq($sformatf("%s cnt[%0d]", tag, ch), 32'(cnt_s[ch*CNT_W +: CNT_W]), m_cnt[ch]);
      any_exp |= m_match[ch];
    end
    check_eq($sformatf("%s any_match", tag), 32'(any_s), 32'(any_exp));
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    compare_all(tag);
    cfg_we  = 1'b0;
    cnt_clr = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    check_eq({tag, " match"}, 32'(match_s), 0);
    check_eq({tag, " any"}, 32'(any_s), 0);
    check_eq({tag, " cnt"}, 32'(cnt_s), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
  endtask

  task automatic cfg_write(input logic [CH_W-1:0] ch, input logic [MAX_LEN-1:0] pat,
                           input logic [LEN_W-1:0] len, input logic ov, input string tag);
    din         = '0;
    cfg_we      = 1'b1;
    cfg_ch      = ch;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ov;
    step(tag);
  endtask

  task automatic send0(input logic b, input string tag);
    din    = '0;
    din[0] = b;
    step(tag);
  endtask

  task automatic send_stream0(input logic [15:0] bits, input int n, input string tag);
    for (int k = n - 1; k >= 0; k--) send0(bits[k], tag);
  endtask

  task automatic clear_counts();
    din     = '0;
    cnt_clr = 1'b1;
    step("clr");
  endtask

  initial begin
    model_clear();
    do_reset("reset");

    // Overlapping 1011 on stream 1011011: hits after bits 4 and 7.
    cfg_write(0, 8'b1011, 4, 1'b1, "ovl cfg");
    send_stream0(16'b1011011, 7, "ovl");
    check_eq("ovl final cnt0", 32'(cnt_s[0 +: CNT_W]), 2);

    clear_counts();
    cfg_write(0, 8'b1011, 4, 1'b0, "novl cfg");
    send_stream0(16'b1011011, 7, "novl");
    check_eq("novl final cnt0", 32'(cnt_s[0 +: CNT_W]), 1);

    // Independent channels with simultaneous hits.
    clear_counts();
    cfg_write(0, 8'b11, 2, 1'b1, "ind cfg0");
    cfg_write(1, 8'b010, 3, 1'b1, "ind cfg1");
    din = 3'b001; step("ind b1");
    din = 3'b011; step("ind b2");
    din = 3'b001; step("ind b3");
    check_eq("ind any at b3", 32'(any_s), 1);
    check_eq("ind cnt0", 32'(cnt_s[0 +: CNT_W]), 2);
    check_eq("ind cnt1", 32'(cnt_s[CNT_W +: CNT_W]), 1);

    // Counter saturation, then clear winning over a same-cycle hit.
    clear_counts();
    cfg_write(0, 8'b1, 1, 1'b1, "sat cfg");
    for (int n = 0; n < 300; n++) send0(1'b1, "sat");
    check_eq("sat cnt0", 32'(cnt_s[0 +: CNT_W]), CNT_SAT);
    din = 3'b001; cnt_clr = 1'b1; step("sat clr");
    check_eq("sat clr cnt0", 32'(cnt_s[0 +: CNT_W]), 0);
    check_eq("sat clr hit", 32'(match_s[0]), 1);

    // Disable, reconfigure or reset after a partial 101 of 1011.
    cfg_write(0, 8'b1011, 4, 1'b1, "mid cfg");
    send_stream0(16'b101, 3, "dis pre");
    ch_en[0] = 1'b0; send0(1'b1, "dis off");
    ch_en[0] = 1'b1; send0(1'b1, "dis last");
    check_eq("dis no match", 32'(match_s[0]), 0);
    send_stream0(16'b101, 3, "rcfg pre");
    cfg_write(0, 8'b1011, 4, 1'b1, "rcfg cfg");
    send0(1'b1, "rcfg last");
    check_eq("rcfg no match", 32'(match_s[0]), 0);
    send_stream0(16'b101, 3, "rst pre");
    do_reset("rst mid");
    cfg_write(0, 8'b1011, 4, 1'b1, "rst cfg");
    send0(1'b1, "rst last");
    check_eq("rst no match", 32'(match_s[0]), 0);

    // Zero length never matches.
    cfg_write(0, 8'h00, 0, 1'b1, "len0 cfg");
    for (int n = 0; n < 20; n++) send0(1'($urandom), "len0");
    check_eq("len0 cnt0", 32'(cnt_s[0 +: CNT_W]), 0);

    // Over-long length clamps to MAX_LEN.
    cfg_write(0, 8'hA5, 15, 1'b0, "clamp cfg");
    send_stream0(16'hA5, 8, "clamp");
    check_eq("clamp match", 32'(match_s[0]), 1);
    check_eq("clamp cnt0", 32'(cnt_s[0 +: CNT_W]), 1);

    // Write to a nonexistent channel must leave every channel unchanged.
    cfg_write(2'(NUM_CH), 8'h00, 1, 1'b1, "badch cfg");
    send_stream0(16'hA5, 8, "badch");
    check_eq("badch cnt0", 32'(cnt_s[0 +: CNT_W]), 2);

    // Randomized traffic with occasional reconfiguration, disables, clears and resets.
    for (int n = 0; n < 3000; n++) begin
      din     = NUM_CH'($urandom);
      ch_en   = ($urandom_range(0, 15) == 0) ? NUM_CH'($urandom) : '1;
      cnt_clr = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 15) == 0) begin
        cfg_we      = 1'b1;
        cfg_ch      = CH_W'($urandom_range(0, 3));
        cfg_len     = ($urandom_range(0, 7) == 0) ? LEN_W'($urandom) : LEN_W'($urandom_range(1, 4));
        cfg_pattern = MAX_LEN'($urandom);
        cfg_overlap = 1'($urandom_range(0, 1));
      end
      step("rnd");
      if ($urandom_range(0, 499) == 0) do_reset("rnd reset");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_detect_multi.md
Name: seq_detect_multi

Overview:
Parametrised bank of NUM_CH independent serial pattern detectors. Each channel runs a runtime-programmable pattern (length 1..MAX_LEN) on its own 1-bit input stream. Overlap or non-overlap matching is selected per channel. The block produces per-channel match pulses, a combined any-match flag and saturating per-channel match counters. It replaces the fixed-pattern three-input detector in the sequence-monitor path.

Parameters:
NUM_CH, 4, number of independent detector channels (>=1)
MAX_LEN, 8, maximum pattern length in bits (>=2)
CNT_W, 8, width of each per-channel match counter

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state
cfg_we  input  1  config write strobe, one cycle
cfg_ch  input  CH_W=max(1,$clog2(NUM_CH))  target channel of config write
cfg_pattern  input  MAX_LEN  pattern; bit[len-1] = first bit received, bit[0] = last bit received
cfg_len  input  LEN_W=$clog2(MAX_LEN+1)  pattern length
cfg_overlap  input  1  1 = overlapping matches allowed, 0 = history restarts after match
ch_en  input  NUM_CH  per-channel enable
din  input  NUM_CH  serial data; bit i feeds channel i, sampled every clock
cnt_clr  input  1  synchronous clear of all match counters
match  output  NUM_CH  registered one-cycle match pulse per channel
any_match  output  1  OR of match bits (combinational from match register)
match_cnt  output  NUM_CH*CNT_W  channel i counter at [i*CNT_W +: CNT_W]

Behaviour:
- Reset (async): pattern=0, len=0, overlap=0, hist=0, fill=0, match=0, counters=0 for every channel; any_match=0.
- Per-channel state: pattern[MAX_LEN], len, overlap, hist[MAX_LEN], fill (0..MAX_LEN, saturating).
- Enabled channel, each edge: hist_n = {hist[MAX_LEN-2:0], din[i]}; fill_n = min(fill+1, MAX_LEN).
- Hit condition: len != 0 AND fill_n >= len AND hist_n[len-1:0] == pattern[len-1:0]; only the low len bits are compared.
- On hit: match[i] <= 1 for exactly one cycle. Latency: match is high in the cycle after the edge that sampled the final pattern bit.
- On hit with overlap=1: hist <= hist_n, fill <= fill_n.
- On hit with overlap=0: hist <= 0, fill <= 0, so the next match needs len fresh bits.
- No hit: match[i] <= 0.
- ch_en[i]=0: hist, fill and match[i] cleared to 0 each cycle. Counter and config are held.
- Config write (cfg_we=1, cfg_ch < NUM_CH):
  - Loads pattern, len and overlap into the target channel.
  - Clears that channel's hist, fill and match; din for that channel is ignored that cycle.
  - cfg_len > MAX_LEN is clamped to MAX_LEN.
  - cfg_len = 0 disables matching on the channel.
  - cfg_ch >= NUM_CH: write ignored.
  - Other channels are unaffected.
- Counters: match_cnt[i] increments by 1 on each hit and saturates at 2^CNT_W-1 (no wrap).
- cnt_clr=1 zeroes all counters and has priority over a same-cycle hit (result 0).
- Reset mid-stream: all partial history is lost immediately; no match pulse is generated from pre-reset bits.
- Channels are fully independent; simultaneous hits on several channels set all corresponding match bits and any_match.

Test Plan:
- Overlap: ch0 cfg pattern=4'b1011, len=4, overlap=1, ch_en=1. din[0] stream 1,0,1,1,0,1,1 -> match[0] pulses after bits 4 and 7; match_cnt[0]=2.
- Non-overlap: same stream with overlap=0 -> single pulse after bit 4; match_cnt[0]=1.
- Independence: ch0 len=2 pattern 2'b11; ch1 len=3 pattern 3'b010. din[0]=1,1,1 and din[1]=0,1,0 -> match[0] pulses after bits 2 and 3, match[1] after bit 3, any_match=1 at both points, cnt0=2, cnt1=1.
- Saturation/clear: CNT_W=8, ch0 len=1 pattern 1'b1, din[0]=1 for 300 cycles -> cnt0 stops at 255. Assert cnt_clr together with a hit -> cnt0=0 the following cycle.
- Disable, reconfig and reset mid-pattern: feed 1,0,1 of 1011.
  - Pulse ch_en[0]=0 then send 1 -> no match.
  - Repeat, but rewrite cfg for ch0 -> no match.
  - Repeat, but assert reset between bits -> no match and all outputs 0.
- Boundaries:
  - len=0 -> no match for any input.
  - cfg_len=15 with MAX_LEN=8 -> behaves as len=8 (pattern 8'hA5 matches after 8 bits).
  - cfg_ch=NUM_CH -> no channel config changes.
